// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the controller state encoding, opcode/funct constants and ALU operation codes.
package mc_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the sequencing controller and the datapath.
// master = controller (consumes IR fields/flags, drives enables); slave = datapath.
interface mc_control_if;
  import mc_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic [OP_W-1:0]    funct;
  logic               zero;
  logic               mem_ready;

  logic               mem_req;
  logic               mem_write;
  logic               i_or_d;
  logic               ir_write;
  logic               pc_en;
  logic [1:0]         pc_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] aluop;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg, reg_write, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg, reg_write, illegal
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU operation decoder, purely combinational.
// Unknown funct codes fall back to ADD and raise funct_illegal.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]    funct,
  output logic [ALUOP_W-1:0] aluop,
  output logic               funct_illegal
);

  // Map the funct field onto the shared ALU operation code
  always_comb begin
    aluop         = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  aluop = ALU_ADD;
      FN_SUB:  aluop = ALU_SUB;
      FN_AND:  aluop = ALU_AND;
      FN_OR:   aluop = ALU_OR;
      FN_SLT:  aluop = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Moore sequencing controller for the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// stalls on the memory req/ready handshake.
// Optional: define MC_CONTROL_PERF_CNT_EN to add cycle and retired-instruction counters.
module mc_control
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mc_control_if.master       bus
`ifdef MC_CONTROL_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  state_t             state_reg;
  state_t             state_next;

  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_funct_illegal;

  logic               pc_write;
  logic               branch;
  logic               mem_req;
  logic               mem_write;
  logic               i_or_d;
  logic               ir_write;
  logic [1:0]         pc_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] aluop;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               illegal;

  mc_alu_decoder u_alu_decoder (
    .funct         (bus.funct),
    .aluop         (dec_aluop),
    .funct_illegal (dec_funct_illegal)
  );

  // State register; reset aborts any instruction in flight immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = '0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        aluop     = ALU_ADD;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // ALU precomputes PC+4 + (imm<<2) as a speculative branch target
        alu_src_b = 2'b11;
        aluop     = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        aluop      = ALU_ADD;
        state_next = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (bus.mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) state_next = FETCH;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = dec_aluop;
        if (dec_funct_illegal) begin
          illegal    = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = ALUWB;
        end
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        aluop      = ALU_SUB;
        pc_src     = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        aluop      = ALU_ADD;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      // Unencoded state values recover through IDLE with all outputs quiet
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_write  = mem_write;
  assign bus.i_or_d     = i_or_d;
  assign bus.ir_write   = ir_write;
  assign bus.pc_en      = pc_write | (branch & bus.zero);
  assign bus.pc_src     = pc_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.aluop      = aluop;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.illegal    = illegal;

`ifdef MC_CONTROL_PERF_CNT_EN
  logic retire;

  // An instruction retires when a completing state hands back to FETCH;
  // illegal returns from DECODE/EXECUTE are deliberately excluded
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
      MEMWRITE:                           retire = bus.mem_ready;
      default:                            retire = 1'b0;
    endcase
  end

  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_reg != IDLE) cycle_cnt   <= cycle_cnt + 32'd1;
      if (retire)            instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control.
// Each cycle the full output vector is compared against hand-derived values.
module tb_mc_control;

  logic clk;
  logic rst_n;

  mc_control_if bus ();

`ifdef MC_CONTROL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MC_CONTROL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: mem_req mem_write i_or_d ir_write pc_en pc_src[2] alu_src_a
  //              alu_src_b[2] aluop[3] reg_dst mem_to_reg reg_write illegal
  logic [16:0] sig;
  assign sig = {bus.mem_req, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_en,
                bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.aluop,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal};

  localparam logic [16:0] S_IDLE     = 17'b0;
  localparam logic [16:0] S_FETCH_R  = 17'b1_0_0_1_1_00_0_01_010_0_0_0_0;
  localparam logic [16:0] S_FETCH_W  = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
  localparam logic [16:0] S_DECODE   = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
  localparam logic [16:0] S_DEC_ILL  = 17'b0_0_0_0_0_00_0_11_010_0_0_0_1;
  localparam logic [16:0] S_MEMADR   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] S_MEMREAD  = 17'b1_0_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] S_MEMWB    = 17'b0_0_0_0_0_00_0_00_000_0_1_1_0;
  localparam logic [16:0] S_MEMWRITE = 17'b1_1_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] S_EXEC_SLT = 17'b0_0_0_0_0_00_1_00_111_0_0_0_0;
  localparam logic [16:0] S_EXEC_ILL = 17'b0_0_0_0_0_00_1_00_010_0_0_0_1;
  localparam logic [16:0] S_ALUWB    = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
  localparam logic [16:0] S_BR_T     = 17'b0_0_0_0_1_01_1_00_110_0_0_0_0;
  localparam logic [16:0] S_BR_N     = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
  localparam logic [16:0] S_ADDIEX   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] S_ADDIWB   = 17'b0_0_0_0_0_00_0_00_000_0_0_1_0;
  localparam logic [16:0] S_JUMP     = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;

  int checks_total;
  int checks_passed;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 6'b000000;
    bus.funct = 6'b100000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if (sig !== S_IDLE) $display("FAIL reset_held: got %b expected %b", sig, S_IDLE);
    else checks_passed++;
    rst_n = 1'b1;
    #1;
    checks_total++;
    if (sig !== S_IDLE) $display("FAIL reset_idle: got %b expected %b", sig, S_IDLE);
    else checks_passed++;
    @(posedge clk);
    #1;
    checks_total++;
    if (sig !== S_FETCH_R) $display("FAIL reset_first_fetch: got %b expected %b", sig, S_FETCH_R);
    else checks_passed++;
    $display("txn reset: idle then fetch");
  endtask

  task automatic test_lw();
    logic [16:0] ex [8] = '{S_FETCH_R, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD,
                            S_MEMREAD, S_MEMWB, S_FETCH_R};
    logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks_total++;
      if (sig !== ex[i]) $display("FAIL lw_step%0d: got %b expected %b", i, sig, ex[i]);
      else checks_passed++;
      if (i < 7) begin @(posedge clk); #1; end
    end
    $display("txn lw with 2 wait cycles");
  endtask

  task automatic test_rtype();
    logic [16:0] ex [5] = '{S_FETCH_R, S_DECODE, S_EXEC_SLT, S_ALUWB, S_FETCH_R};
    bus.opcode = 6'b000000;
    bus.funct = 6'b101010;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks_total++;
      if (sig !== ex[i]) $display("FAIL rtype_slt_step%0d: got %b expected %b", i, sig, ex[i]);
      else checks_passed++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    $display("txn rtype slt");
  endtask

  task automatic test_beq();
    logic [16:0] ex [7] = '{S_FETCH_R, S_DECODE, S_BR_T, S_FETCH_R, S_DECODE, S_BR_N, S_FETCH_R};
    logic        zr [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.opcode = 6'b000100;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.zero = zr[i];
      #1;
      checks_total++;
      if (sig !== ex[i]) $display("FAIL beq_step%0d: got %b expected %b", i, sig, ex[i]);
      else checks_passed++;
      if (i < 6) begin @(posedge clk); #1; end
    end
    bus.zero = 1'b0;
    $display("txn beq taken then not taken");
  endtask

  task automatic test_illegal();
    logic [16:0] ex [6] = '{S_FETCH_R, S_DEC_ILL, S_FETCH_R, S_DECODE, S_EXEC_ILL, S_FETCH_R};
    logic [5:0]  op [6] = '{6'b111111, 6'b111111, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    bus.funct = 6'b000111;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.opcode = op[i];
      #1;
      checks_total++;
      if (sig !== ex[i]) $display("FAIL illegal_step%0d: got %b expected %b", i, sig, ex[i]);
      else checks_passed++;
      if (i < 5) begin @(posedge clk); #1; end
    end
    $display("txn illegal opcode then illegal funct");
  endtask

  task automatic test_back_to_back();
    logic [16:0] ex [8] = '{S_FETCH_R, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH_R, S_DECODE, S_JUMP, S_FETCH_W};
    logic [5:0]  op [8] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
                            6'b000010, 6'b000010, 6'b000010, 6'b000010};
    logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.opcode = op[i];
      bus.mem_ready = rd[i];
      #1;
      checks_total++;
      if (sig !== ex[i]) $display("FAIL b2b_step%0d: got %b expected %b", i, sig, ex[i]);
      else checks_passed++;
      if (i < 7) begin @(posedge clk); #1; end
    end
    // A stalled fetch must hold: still FETCH one cycle later
    @(posedge clk);
    #1;
    checks_total++;
    if (sig !== S_FETCH_W) $display("FAIL fetch_stall_hold: got %b expected %b", sig, S_FETCH_W);
    else checks_passed++;
    $display("txn addi then j then fetch stall");
  endtask

  task automatic test_reset_abort();
    logic [16:0] ex [4] = '{S_FETCH_R, S_DECODE, S_MEMADR, S_MEMWRITE};
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks_total++;
      if (sig !== ex[i]) $display("FAIL sw_step%0d: got %b expected %b", i, sig, ex[i]);
      else checks_passed++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    // Assert reset between edges: outputs must drop without a clock edge
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (bus.mem_req !== 1'b0) $display("FAIL abort_mem_req: got %b expected 0", bus.mem_req);
    else checks_passed++;
    checks_total++;
    if (bus.mem_write !== 1'b0) $display("FAIL abort_mem_write: got %b expected 0", bus.mem_write);
    else checks_passed++;
    checks_total++;
    if (sig !== S_IDLE) $display("FAIL abort_all: got %b expected %b", sig, S_IDLE);
    else checks_passed++;
`ifdef MC_CONTROL_PERF_CNT_EN
    checks_total++;
    if (cycle_cnt !== 32'd0) $display("FAIL abort_cycle_cnt: got %0d expected 0", cycle_cnt);
    else checks_passed++;
    checks_total++;
    if (instret_cnt !== 32'd0) $display("FAIL abort_instret_cnt: got %0d expected 0", instret_cnt);
    else checks_passed++;
`endif
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks_total++;
    if (sig !== S_IDLE) $display("FAIL abort_idle: got %b expected %b", sig, S_IDLE);
    else checks_passed++;
    @(posedge clk);
    #1;
    checks_total++;
    if (sig !== S_FETCH_R) $display("FAIL abort_refetch: got %b expected %b", sig, S_FETCH_R);
    else checks_passed++;
    $display("txn sw aborted by reset");
  endtask

  initial begin
    checks_total = 0;
    checks_passed = 0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Main sequencing controller for the multicycle MIPS datapath. It is a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the shared 3-bit ALU operation code and the operand-select, register-file, PC and memory enables. Memory accesses use a req/ready handshake, so fetch and load/store stall until memory responds.

Parameters:
- OP_W, 6, opcode and funct field width
- ALUOP_W, 3, ALU operation code width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous reset, active-low
- opcode  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag (meaningful for SUB only)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  1 = write, 0 = read (valid with mem_req)
- i_or_d  out  1  address mux: 0 = PC, 1 = ALUOut
- ir_write  out  1  IR load enable
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
- aluop  out  3  010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- Async reset forces state IDLE. In IDLE every output is 0, aluop included.
- IDLE always moves to FETCH on the next edge, so the first fetch request appears 1 cycle after reset release.
- Outputs decode from state only, plus mem_ready and zero where listed below. Outputs not listed for a state are 0.
- FETCH:
  - mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=ADD, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, aluop=ADD (speculative branch target). Next state by opcode:
  - 100011 / 101011 go to MEMADR.
  - 000000 goes to EXECUTE.
  - 000100 goes to BRANCH.
  - 001000 goes to ADDIEX.
  - 000010 goes to JUMP.
  - Any other opcode pulses illegal and returns to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, i_or_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, aluop from funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - An unknown funct gives aluop=ADD, pulses illegal and goes to FETCH with no writeback.
  - Otherwise goes to ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=SUB, pc_src=01, branch=1. pc_en=zero. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD. Goes to ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1. Goes to FETCH.
- JUMP: pc_src=10, pc_write=1. Goes to FETCH.
- Latencies with zero memory wait:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each mem_ready=0 cycle adds 1.
- A reset asserted mid-instruction aborts it immediately; no partial writeback.
- The state register must never hold an unencoded value; any such value returns to IDLE.

Optional Feature:
Macro MC_CONTROL_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both cleared by reset.
  - cycle_cnt increments every cycle outside IDLE.
  - instret_cnt increments on each transition into FETCH from a completing state (MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH, ADDIWB, JUMP). Illegal returns do not count.
  - Both counters wrap at 2^32.
- When undefined: the ports and logic are absent.

Decomposition:
- Package mc_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - aluop constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
- One sub-module, mc_alu_decoder: combinational funct to aluop plus funct_illegal. It is reused by the pipelined control.

Test Plan:
- Reset release with opcode=0, mem_ready=1: 1 cycle in IDLE with all outputs 0, then FETCH with mem_req=1, alu_src_b=01, aluop=010, ir_write=1, pc_en=1.
- lw (100011) with mem_ready held 0 for 2 cycles in MEMREAD: visits FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB; reg_write=1 with mem_to_reg=1; 7 cycles total.
- R-type funct=101010: EXECUTE drives aluop=111, then ALUWB drives reg_dst=1, reg_write=1.
- beq (000100): zero=1 gives pc_en=1, pc_src=01 in BRANCH. Repeat with zero=0: pc_en=0. Both return to FETCH.
- opcode=111111 pulses illegal for 1 cycle in DECODE, then FETCH with no reg_write or mem_write. funct=000111 likewise pulses illegal in EXECUTE.
- rst_n low while in MEMWRITE with mem_req=1: mem_req and mem_write drop the same cycle (asynchronously). With MC_CONTROL_PERF_CNT_EN, the counters read 0.
